// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared encodings and field offsets for the TLB maintenance sequencer
package tlb_pkg;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ELO_V      = 0;
    localparam int ELO_D      = 1;
    localparam int ELO_PLV_LO = 2;
    localparam int ELO_MAT_LO = 4;
    localparam int ELO_G      = 6;
    localparam int ELO_PPN_LO = 8;
    localparam int IDX_PS_LO  = 24;
    localparam int IDX_NE     = 31;

    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [5:0] PS_4K      = 6'd12;
    localparam logic [5:0] PS_4M      = 6'd22;

    // Rebuild a TLBELO word from the per-page fields of a TLB entry.
    function automatic logic [31:0] pack_elo(input logic [19:0] ppn, input logic g,
                                             input logic [1:0] mat, input logic [1:0] plv,
                                             input logic d, input logic v);
        return {4'b0, ppn, 1'b0, g, mat, plv, d, v};
    endfunction

endpackage

// File: rtl/tlb_op_unit_if.sv
// rtl/tlb_op_unit_if.sv - request/result handshake between WB-stage CSR logic and the sequencer
interface tlb_op_unit_if #(parameter int IW = 4);
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [4:0]    req_inv_op;
    logic [9:0]    req_inv_asid;
    logic [31:0]   req_inv_va;
    logic          done_valid;
    logic [2:0]    res_op;
    logic          res_ne;
    logic [IW-1:0] res_index;
    logic [18:0]   res_ehi_vppn;
    logic [5:0]    res_ps;
    logic [9:0]    res_asid;
    logic [31:0]   res_elo0;
    logic [31:0]   res_elo1;

    modport master (
        output req_valid, req_op, req_inv_op, req_inv_asid, req_inv_va,
        input  req_ready, done_valid, res_op, res_ne, res_index, res_ehi_vppn,
               res_ps, res_asid, res_elo0, res_elo1
    );

    modport slave (
        input  req_valid, req_op, req_inv_op, req_inv_asid, req_inv_va,
        output req_ready, done_valid, res_op, res_ne, res_index, res_ehi_vppn,
               res_ps, res_asid, res_elo0, res_elo1
    );
endinterface

// File: rtl/tlb_fill_cnt.sv
// rtl/tlb_fill_cnt.sv - free-running wrapping counter used as the TLBFILL victim index
module tlb_fill_cnt #(
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          reset,
    output logic [IW-1:0] cnt
);

    // Advance every cycle; natural IW-bit overflow gives the TLBNUM-1 -> 0 wrap.
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/tlb_op_unit.sv
// rtl/tlb_op_unit.sv - sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB driving TLB port 1
module tlb_op_unit
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    tlb_op_unit_if.slave  bus,
    input  logic [9:0]    csr_asid,
    input  logic [18:0]   csr_ehi_vppn,
    input  logic [31:0]   csr_idx,
    input  logic [31:0]   csr_elo0,
    input  logic [31:0]   csr_elo1,
    input  logic [5:0]    csr_ecode,
    output logic [18:0]   s1_vppn,
    output logic          s1_va_bit12,
    output logic [9:0]    s1_asid,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,
    output logic          s1_busy,
    output logic          invtlb_valid,
    output logic [4:0]    invtlb_op,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic          w_e,
    output logic [18:0]   w_vppn,
    output logic [5:0]    w_ps,
    output logic [9:0]    w_asid,
    output logic          w_g,
    output logic [19:0]   w_ppn0,
    output logic [1:0]    w_plv0,
    output logic [1:0]    w_mat0,
    output logic          w_d0,
    output logic          w_v0,
    output logic [19:0]   w_ppn1,
    output logic [1:0]    w_plv1,
    output logic [1:0]    w_mat1,
    output logic          w_d1,
    output logic          w_v1,
    output logic [IW-1:0] r_index,
    input  logic          r_e,
    input  logic [18:0]   r_vppn,
    input  logic [5:0]    r_ps,
    input  logic [9:0]    r_asid,
    input  logic          r_g,
    input  logic [19:0]   r_ppn0,
    input  logic [1:0]    r_plv0,
    input  logic [1:0]    r_mat0,
    input  logic          r_d0,
    input  logic          r_v0,
    input  logic [19:0]   r_ppn1,
    input  logic [1:0]    r_plv1,
    input  logic [1:0]    r_mat1,
    input  logic          r_d1,
    input  logic          r_v1
);

    state_t        state, state_nxt;
    logic [2:0]    op_q;
    logic [IW-1:0] fill_cnt;
    logic          accept;

    logic unused_csr_bits;
    assign unused_csr_bits = ^{csr_idx[30], csr_idx[23:IW], csr_elo0[31:28], csr_elo0[7],
                               csr_elo1[31:28], csr_elo1[7]};

    tlb_fill_cnt #(.IW(IW)) u_fill_cnt (
        .clk   (clk),
        .reset (reset),
        .cnt   (fill_cnt)
    );

    assign accept     = bus.req_valid & bus.req_ready;
    assign bus.res_op = op_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and one-cycle strobes; strobes are masked by reset so an op
    // caught by reset in EXEC/DONE never writes, invalidates or completes.
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.done_valid = 1'b0;
        we             = 1'b0;
        invtlb_valid   = 1'b0;
        s1_busy        = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt    = ST_DONE;
                we           = ~reset & ((op_q == OP_WR) | (op_q == OP_FILL));
                s1_busy      = ~reset & ((op_q == OP_SRCH) | (op_q == OP_INV));
                invtlb_valid = ~reset & (op_q == OP_INV) & (invtlb_op <= 5'd6);
            end
            ST_DONE: begin
                state_nxt      = ST_IDLE;
                bus.done_valid = ~reset;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Latch request/CSR operands straight into the registered TLB drives on
    // accept, then capture lookup/read results at the end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q             <= '0;
            invtlb_op        <= '0;
            s1_vppn          <= '0;
            s1_va_bit12      <= 1'b0;
            s1_asid          <= '0;
            r_index          <= '0;
            w_index          <= '0;
            w_e              <= 1'b0;
            w_vppn           <= '0;
            w_ps             <= '0;
            w_asid           <= '0;
            w_g              <= 1'b0;
            w_ppn0           <= '0;
            w_plv0           <= '0;
            w_mat0           <= '0;
            w_d0             <= 1'b0;
            w_v0             <= 1'b0;
            w_ppn1           <= '0;
            w_plv1           <= '0;
            w_mat1           <= '0;
            w_d1             <= 1'b0;
            w_v1             <= 1'b0;
            bus.res_ne       <= 1'b0;
            bus.res_index    <= '0;
            bus.res_ehi_vppn <= '0;
            bus.res_ps       <= '0;
            bus.res_asid     <= '0;
            bus.res_elo0     <= '0;
            bus.res_elo1     <= '0;
        end else begin
            if (accept) begin
                op_q      <= bus.req_op;
                invtlb_op <= bus.req_inv_op;
                case (bus.req_op)
                    OP_SRCH: begin
                        s1_vppn     <= csr_ehi_vppn;
                        s1_va_bit12 <= 1'b0;
                        s1_asid     <= csr_asid;
                    end
                    OP_RD: r_index <= csr_idx[IW-1:0];
                    OP_WR, OP_FILL: begin
                        w_index <= (bus.req_op == OP_WR) ? csr_idx[IW-1:0] : fill_cnt;
                        w_e     <= (csr_ecode == ECODE_TLBR) ? 1'b1 : ~csr_idx[IDX_NE];
                        w_vppn  <= csr_ehi_vppn;
                        w_ps    <= csr_idx[IDX_PS_LO +: 6];
                        w_asid  <= csr_asid;
                        w_g     <= csr_elo0[ELO_G] & csr_elo1[ELO_G];
                        w_ppn0  <= csr_elo0[ELO_PPN_LO +: 20];
                        w_plv0  <= csr_elo0[ELO_PLV_LO +: 2];
                        w_mat0  <= csr_elo0[ELO_MAT_LO +: 2];
                        w_d0    <= csr_elo0[ELO_D];
                        w_v0    <= csr_elo0[ELO_V];
                        w_ppn1  <= csr_elo1[ELO_PPN_LO +: 20];
                        w_plv1  <= csr_elo1[ELO_PLV_LO +: 2];
                        w_mat1  <= csr_elo1[ELO_MAT_LO +: 2];
                        w_d1    <= csr_elo1[ELO_D];
                        w_v1    <= csr_elo1[ELO_V];
                    end
                    OP_INV: begin
                        s1_vppn     <= bus.req_inv_va[31:13];
                        s1_va_bit12 <= bus.req_inv_va[12];
                        s1_asid     <= bus.req_inv_asid;
                    end
                    default: ;
                endcase
            end
            if (state == ST_EXEC) begin
                case (op_q)
                    OP_SRCH: begin
                        bus.res_ne    <= ~s1_found;
                        bus.res_index <= s1_found ? s1_index : '0;
                    end
                    OP_RD: begin
                        bus.res_ne       <= ~r_e;
                        bus.res_ehi_vppn <= r_e ? r_vppn : '0;
                        bus.res_ps       <= r_e ? r_ps : '0;
                        bus.res_asid     <= r_e ? r_asid : '0;
                        bus.res_elo0     <= r_e ? pack_elo(r_ppn0, r_g, r_mat0, r_plv0, r_d0, r_v0) : '0;
                        bus.res_elo1     <= r_e ? pack_elo(r_ppn1, r_g, r_mat1, r_plv1, r_d1, r_v1) : '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tlb_op_unit.sv
// tb/tb_tlb_op_unit.sv - directed self-checking bench for tlb_op_unit with a behavioural TLB array
module tb_tlb_op_unit;
    localparam int IW = 4;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tlb_op_unit_if #(.IW(IW)) bus ();

    logic [9:0]    csr_asid;
    logic [18:0]   csr_ehi_vppn;
    logic [31:0]   csr_idx, csr_elo0, csr_elo1;
    logic [5:0]    csr_ecode;
    logic [18:0]   s1_vppn;
    logic          s1_va_bit12;
    logic [9:0]    s1_asid;
    logic          s1_found;
    logic [IW-1:0] s1_index;
    logic          s1_busy, invtlb_valid, we;
    logic [4:0]    invtlb_op;
    logic [IW-1:0] w_index, r_index;
    logic          w_e, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [18:0]   w_vppn;
    logic [5:0]    w_ps;
    logic [9:0]    w_asid;
    logic [19:0]   w_ppn0, w_ppn1;
    logic [1:0]    w_plv0, w_mat0, w_plv1, w_mat1;
    logic          r_e, r_g, r_d0, r_v0, r_d1, r_v1;
    logic [18:0]   r_vppn;
    logic [5:0]    r_ps;
    logic [9:0]    r_asid;
    logic [19:0]   r_ppn0, r_ppn1;
    logic [1:0]    r_plv0, r_mat0, r_plv1, r_mat1;

    tlb_op_unit #(.TLBNUM(N)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .csr_asid(csr_asid), .csr_ehi_vppn(csr_ehi_vppn), .csr_idx(csr_idx),
        .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_ecode(csr_ecode),
        .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_busy(s1_busy),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
        .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
        .w_asid(w_asid), .w_g(w_g),
        .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
        .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid),
        .r_g(r_g),
        .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
        .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1)
    );

    // Behavioural TLB array.
    logic        t_e    [N];
    logic [18:0] t_vppn [N];
    logic [5:0]  t_ps   [N];
    logic [9:0]  t_asid [N];
    logic        t_g    [N];
    logic [19:0] t_ppn0 [N], t_ppn1 [N];
    logic [1:0]  t_plv0 [N], t_mat0 [N], t_plv1 [N], t_mat1 [N];
    logic        t_d0   [N], t_v0 [N], t_d1 [N], t_v1 [N];

    function automatic logic va_hit(input int i);
        if (t_ps[i] == 6'd22) return t_vppn[i][18:9] == s1_vppn[18:9];
        return t_vppn[i] == s1_vppn;
    endfunction

    always_comb begin
        s1_found = 1'b0;
        s1_index = '0;
        for (int i = 0; i < N; i++)
            if (t_e[i] && (t_g[i] || t_asid[i] == s1_asid) && va_hit(i)) begin
                s1_found = 1'b1;
                s1_index = IW'(i);
            end
    end

    assign r_e = t_e[r_index];       assign r_vppn = t_vppn[r_index];
    assign r_ps = t_ps[r_index];     assign r_asid = t_asid[r_index];
    assign r_g = t_g[r_index];
    assign r_ppn0 = t_ppn0[r_index]; assign r_plv0 = t_plv0[r_index];
    assign r_mat0 = t_mat0[r_index]; assign r_d0 = t_d0[r_index]; assign r_v0 = t_v0[r_index];
    assign r_ppn1 = t_ppn1[r_index]; assign r_plv1 = t_plv1[r_index];
    assign r_mat1 = t_mat1[r_index]; assign r_d1 = t_d1[r_index]; assign r_v1 = t_v1[r_index];

    always @(posedge clk) begin
        if (we) begin
            t_e[w_index] <= w_e;       t_vppn[w_index] <= w_vppn;
            t_ps[w_index] <= w_ps;     t_asid[w_index] <= w_asid;
            t_g[w_index] <= w_g;
            t_ppn0[w_index] <= w_ppn0; t_plv0[w_index] <= w_plv0; t_mat0[w_index] <= w_mat0;
            t_d0[w_index] <= w_d0;     t_v0[w_index] <= w_v0;
            t_ppn1[w_index] <= w_ppn1; t_plv1[w_index] <= w_plv1; t_mat1[w_index] <= w_mat1;
            t_d1[w_index] <= w_d1;     t_v1[w_index] <= w_v1;
        end
        if (invtlb_valid)
            for (int i = 0; i < N; i++) begin
                case (invtlb_op)
                    5'd0, 5'd1: t_e[i] <= 1'b0;
                    5'd2: if (t_g[i]) t_e[i] <= 1'b0;
                    5'd3: if (!t_g[i]) t_e[i] <= 1'b0;
                    5'd4: if (!t_g[i] && t_asid[i] == s1_asid) t_e[i] <= 1'b0;
                    5'd5: if (!t_g[i] && t_asid[i] == s1_asid && va_hit(i)) t_e[i] <= 1'b0;
                    5'd6: if ((t_g[i] || t_asid[i] == s1_asid) && va_hit(i)) t_e[i] <= 1'b0;
                    default: ;
                endcase
            end
    end

    // Independent fill-counter reference: counts cycles since reset, modulo N.
    logic [IW-1:0] cnt_model;
    always @(posedge clk) begin
        if (reset) cnt_model <= '0;
        else       cnt_model <= cnt_model + 1'b1;
    end

    int checks = 0;
    int failures = 0;
    logic [IW-1:0] exp_fill;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request at a negedge; returns #1 after the accept edge (EXEC cycle).
    task automatic issue(input logic [2:0] op, input logic [4:0] inv_op,
                         input logic [9:0] inv_asid, input logic [31:0] inv_va);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_op       = op;
        bus.req_inv_op   = inv_op;
        bus.req_inv_asid = inv_asid;
        bus.req_inv_va   = inv_va;
        exp_fill         = cnt_model;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            t_e[i] = 0; t_vppn[i] = 0; t_ps[i] = 0; t_asid[i] = 0; t_g[i] = 0;
            t_ppn0[i] = 0; t_plv0[i] = 0; t_mat0[i] = 0; t_d0[i] = 0; t_v0[i] = 0;
            t_ppn1[i] = 0; t_plv1[i] = 0; t_mat1[i] = 0; t_d1[i] = 0; t_v1[i] = 0;
        end
        reset = 1'b1;
        bus.req_valid = 0; bus.req_op = 0; bus.req_inv_op = 0;
        bus.req_inv_asid = 0; bus.req_inv_va = 0;
        csr_asid = 0; csr_ehi_vppn = 0; csr_idx = 0; csr_elo0 = 0; csr_elo1 = 0; csr_ecode = 0;
        step(); step();
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_done", bus.done_valid, 0);
        chk("rst_we", we, 0);
        chk("rst_busy", s1_busy, 0);
        chk("rst_w_index", w_index, 0);
        chk("rst_res_ne", bus.res_ne, 0);
        @(negedge clk);
        reset = 1'b0;

        // WR entry 3: VPPN 0x12345, ASID 5, PS 12, G=0
        csr_asid = 10'd5; csr_ehi_vppn = 19'h12345; csr_idx = 32'h0C000003;
        csr_elo0 = 32'h000ABC13; csr_elo1 = 32'h000ABD13; csr_ecode = 6'h00;
        issue(3'd2, 5'd0, 10'd0, 32'd0);
        chk("wr_ready_exec", bus.req_ready, 0);
        chk("wr_we", we, 1);
        chk("wr_w_index", w_index, 3);
        chk("wr_w_e", w_e, 1);
        chk("wr_w_vppn", w_vppn, 32'h12345);
        chk("wr_w_ps", w_ps, 12);
        chk("wr_w_g", w_g, 0);
        chk("wr_w_ppn1", w_ppn1, 32'hABD);
        chk("wr_done_exec", bus.done_valid, 0);
        step();
        chk("wr_we_off", we, 0);
        chk("wr_done", bus.done_valid, 1);
        chk("wr_res_op", bus.res_op, 2);
        step();
        chk("wr_ready_back", bus.req_ready, 1);
        chk("wr_done_off", bus.done_valid, 0);

        // SRCH hit
        issue(3'd0, 5'd0, 10'd0, 32'd0);
        chk("srch_busy", s1_busy, 1);
        chk("srch_s1_vppn", s1_vppn, 32'h12345);
        chk("srch_s1_asid", s1_asid, 5);
        step();
        chk("srch_busy_off", s1_busy, 0);
        chk("srch_done", bus.done_valid, 1);
        chk("srch_res_op", bus.res_op, 0);
        chk("srch_ne", bus.res_ne, 0);
        chk("srch_index", bus.res_index, 3);
        step();

        // SRCH miss on ASID 6
        csr_asid = 10'd6;
        issue(3'd0, 5'd0, 10'd0, 32'd0);
        step();
        chk("srch_miss_ne", bus.res_ne, 1);
        chk("srch_miss_index", bus.res_index, 0);
        step();

        // RD index 3; CSR change after accept must not matter
        csr_idx = 32'h00000003;
        issue(3'd1, 5'd0, 10'd0, 32'd0);
        csr_idx = 32'h00000007;
        chk("rd_r_index", r_index, 3);
        step();
        chk("rd_done", bus.done_valid, 1);
        chk("rd_ne", bus.res_ne, 0);
        chk("rd_vppn", bus.res_ehi_vppn, 32'h12345);
        chk("rd_asid", bus.res_asid, 5);
        chk("rd_ps", bus.res_ps, 12);
        chk("rd_elo0", bus.res_elo0, 32'h000ABC13);
        chk("rd_elo1", bus.res_elo1, 32'h000ABD13);
        step();
        chk("rd_hold_elo0", bus.res_elo0, 32'h000ABC13);

        // RD unwritten index 9
        csr_idx = 32'h00000009;
        issue(3'd1, 5'd0, 10'd0, 32'd0);
        step();
        chk("rd9_ne", bus.res_ne, 1);
        chk("rd9_vppn", bus.res_ehi_vppn, 0);
        chk("rd9_elo0", bus.res_elo0, 0);
        step();

        // INVTLB op 5, asid 5, va 0x2468A000
        issue(3'd4, 5'd5, 10'd5, 32'h2468A000);
        chk("inv_valid", invtlb_valid, 1);
        chk("inv_op", invtlb_op, 5);
        chk("inv_s1_vppn", s1_vppn, 32'h12345);
        chk("inv_bit12", s1_va_bit12, 0);
        chk("inv_s1_asid", s1_asid, 5);
        chk("inv_busy", s1_busy, 1);
        step();
        chk("inv_valid_off", invtlb_valid, 0);
        chk("inv_done", bus.done_valid, 1);
        chk("inv_res_op", bus.res_op, 4);
        step();

        // RD 3 after invalidation
        csr_idx = 32'h00000003;
        issue(3'd1, 5'd0, 10'd0, 32'd0);
        step();
        chk("rdinv_ne", bus.res_ne, 1);
        chk("rdinv_elo1", bus.res_elo1, 0);
        step();

        // INVTLB op 9: no strobe, still completes
        issue(3'd4, 5'd9, 10'd5, 32'h2468A000);
        chk("inv9_valid", invtlb_valid, 0);
        chk("inv9_busy", s1_busy, 1);
        step();
        chk("inv9_done", bus.done_valid, 1);
        step();

        // No-op opcode 6
        issue(3'd6, 5'd0, 10'd0, 32'd0);
        chk("nop_we", we, 0);
        chk("nop_busy", s1_busy, 0);
        chk("nop_inv", invtlb_valid, 0);
        step();
        chk("nop_done", bus.done_valid, 1);
        chk("nop_res_op", bus.res_op, 6);
        step();

        // FILL with NE=1, ecode TLBR -> w_e=1
        csr_asid = 10'd7; csr_ehi_vppn = 19'h0AAAA; csr_idx = 32'h8C000002; csr_ecode = 6'h3F;
        issue(3'd3, 5'd0, 10'd0, 32'd0);
        chk("fill_we", we, 1);
        chk("fill_w_e", w_e, 1);
        chk("fill_w_index", w_index, exp_fill);
        step(); step();

        // FILL with NE=1, ecode 0 -> w_e=0
        csr_ecode = 6'h00;
        issue(3'd3, 5'd0, 10'd0, 32'd0);
        chk("fill2_we", we, 1);
        chk("fill2_w_e", w_e, 0);
        chk("fill2_w_index", w_index, exp_fill);
        step(); step();

        // Reset during EXEC of a WR
        csr_idx = 32'h0C000005; csr_ecode = 6'h00;
        issue(3'd2, 5'd0, 10'd0, 32'd0);
        reset = 1'b1;
        #1;
        chk("abort_we", we, 0);
        step();
        chk("abort_done", bus.done_valid, 0);
        chk("abort_ready", bus.req_ready, 1);
        chk("abort_w_index", w_index, 0);
        chk("abort_no_write", t_e[5], 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("abort_done2", bus.done_valid, 0);
        chk("abort_ready2", bus.req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlb_op_unit.md
# tlb_op_unit

Sequencer for the LoongArch32 TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB. It sits directly upstream of the TLB array, driving its port-1 lookup, read, write and invalidate inputs. It accepts one committed instruction at a time from the WB-stage CSR logic and returns CSR update data two cycles later.

## Interface
- TLBNUM, 16, number of TLB entries (power of two); IW = $clog2(TLBNUM)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  instruction request
- req_ready  out  1  high only in IDLE
- req_op  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5–7 no-op
- req_inv_op  in  5  INVTLB op field
- req_inv_asid  in  10  rj[9:0] operand
- req_inv_va  in  32  rk operand
- csr_asid  in  10  ASID.ASID
- csr_ehi_vppn  in  19  TLBEHI.VPPN
- csr_idx  in  32  TLBIDX: index[IW-1:0], PS[29:24], NE[31]
- csr_elo0, csr_elo1  in  32 each  V[0] D[1] PLV[3:2] MAT[5:4] G[6] PPN[27:8]
- csr_ecode  in  6  ESTAT.Ecode
- s1_vppn / s1_va_bit12 / s1_asid  out  19/1/10  lookup drive (registered)
- s1_found / s1_index  in  1/IW  lookup result
- s1_busy  out  1  port-1 mux select; load/store is stalled while high
- invtlb_valid / invtlb_op  out  1/5
- we / w_index  out  1/IW; w_e, w_vppn, w_ps, w_asid, w_g, w_{ppn,plv,mat,d,v}{0,1}  out  TLB write-port widths
- r_index  out  IW; r_*  in  TLB read-port bundle
- done_valid  out  1  one-cycle completion pulse
- res_op  out  3  completed opcode
- res_ne  out  1; res_index  out  IW; res_ehi_vppn  out  19; res_ps  out  6; res_asid  out  10; res_elo0/1  out  32

## Operation
- All CSR inputs and req_* are latched on accept (req_valid & req_ready). Later CSR changes do not affect the operation in flight.
- States: IDLE → EXEC → DONE → IDLE. EXEC behaviour depends on the latched op.
- **SRCH**:
  - EXEC drives s1_vppn = ehi_vppn, s1_asid = csr_asid, s1_va_bit12 = 0, and s1_busy = 1. s1_found/s1_index are sampled at the end of EXEC.
  - Found: res_ne = 0, res_index = s1_index.
  - Miss: res_ne = 1, res_index = 0.
- **RD**:
  - EXEC drives r_index = latched csr_idx index, and r_* are sampled.
  - r_e = 1: res_ne = 0, and fields are repacked into res_ehi_vppn, res_ps, res_asid and res_elo0/1, with G copied into both ELO words.
  - r_e = 0: res_ne = 1, and all other res_* fields are 0.
- **WR/FILL**:
  - EXEC pulses we.
  - w_index = latched index (WR) or the fill counter value captured at accept (FILL).
  - w_e = 1 if csr_ecode == 6'h3F, else ~NE.
  - w_g = elo0.G & elo1.G; w_ps = csr_idx PS; remaining fields come from the latched CSRs.
- **INV**:
  - EXEC drives s1_asid = inv_asid, s1_vppn = inv_va[31:13], s1_va_bit12 = inv_va[12], and s1_busy = 1.
  - invtlb_valid = 1 only if inv_op ≤ 6; otherwise no strobe. The INE exception for an illegal inv_op is raised upstream.
- **No-op**: EXEC drives no strobes.
- DONE: done_valid = 1, res_op = latched op. res_* are held until the next DONE.
- Fill counter: IW bits, +1 every cycle, wraps TLBNUM-1 → 0.

## Timing
- Accept at cycle T: EXEC at T+1, done_valid at T+2, req_ready high again at T+3. Fixed latency for every op.
- we, invtlb_valid and s1_busy are high for exactly one cycle: the EXEC cycle.
- s1_*, r_index and w_* outputs are registers; no combinational path from req_* to TLB ports.
- Reset values: state IDLE, req_ready 1, done_valid/we/invtlb_valid/s1_busy 0, all res_*, s1_*, w_*, r_index 0, fill counter 0.
- Reset asserted in EXEC or DONE: the op is aborted in the next cycle, with no done_valid and no write.
- req_valid while not ready: ignored; the requester holds the request.

## Structure
- Shared package `tlb_pkg`:
  - op encodings
  - state encoding
  - ELO/TLBIDX bit offsets
  - ECODE_TLBR = 6'h3F
  - PS_4K = 12, PS_4M = 22
- One sub-module, `tlb_fill_cnt` (wrapping free-running counter); everything else is inline.

## Test plan
- Write entry 3 (VPPN 0x12345, ASID 5, G=0, PS 12) via WR with NE=0, then SRCH with ehi_vppn 0x12345, ASID 5 → done at T+2, res_ne=0, res_index=3.
- SRCH on the same entry with ASID 6 → res_ne=1, res_index=0.
- RD index 3 → res_ehi_vppn 0x12345, res_asid 5, res_ps 12, ELO words match the written ones. RD of an unwritten/invalidated index → res_ne=1, all fields 0.
- FILL with NE=1, ecode 0x3F → w_e=1 and w_index equals the counter value at accept. Repeat with ecode 0 → w_e=0.
- INV op 5, asid 5, va 0x2468A000 → invtlb_valid one cycle, s1_vppn 0x12345, s1_va_bit12 0. INV op 9 → no strobe, done_valid still at T+2.
- Reset pulsed in the EXEC cycle of a WR → we stays 0, no done_valid, req_ready=1 after reset.
